// File: rtl/traffic_mch_gen.sv
// traffic_mch_gen: NUM_CH periodic UL/DL packet-ID channels merged round-robin
// onto one valid/ready stream. An event that finds its channel still pending is
// dropped. Define TRAFFIC_DROP_CNT_EN to build the 16-bit saturating drop counter;
// without it o_drop_cnt is tied to 0.
module traffic_mch_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned PERIOD_W = 4,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ena,
  input  logic [2*NUM_CH-1:0]        i_ch_mode,
  input  logic [PERIOD_W*NUM_CH-1:0] i_cfg_period,
  input  logic                       i_seed_load,
  input  logic [ID_W-1:0]            i_seed,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [ID_W-1:0]            o_packet_id,
  output logic                       o_dir_dl,
  output logic [CH_W-1:0]            o_ch,
  output logic [7:0]                 o_seq,
  output logic                       o_drop_pulse,
  output logic [15:0]                o_drop_cnt
);

  localparam logic [1:0] ModeIdle = 2'b00;
  localparam logic [1:0] ModeUl   = 2'b01;
  localparam logic [1:0] ModeDl   = 2'b10;
  localparam logic [1:0] ModeAlt  = 2'b11;

  // Feedback taps: bits 7,5,4,3 for 8-bit IDs, bits 15,14,12,3 for 16-bit IDs.
  localparam logic [15:0]     TapsFull = (ID_W == 16) ? 16'hD008 : 16'h00B8;
  localparam logic [ID_W-1:0] Taps     = TapsFull[ID_W-1:0];

  if (!((ID_W == 8) || (ID_W == 16))) begin : g_bad_id_w
    $error("traffic_mch_gen: ID_W must be 8 or 16");
  end
  if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
    $error("traffic_mch_gen: NUM_CH must be 1..8");
  end

  function automatic logic [ID_W-1:0] f_lfsr_next(input logic [ID_W-1:0] v);
    return {v[ID_W-2:0], ^(v & Taps)};
  endfunction

  function automatic logic [ID_W-1:0] f_rotl(input logic [ID_W-1:0] v, input int unsigned sh);
    logic [2*ID_W-1:0] dbl;
    dbl = {v, v} << sh;
    return dbl[2*ID_W-1:ID_W];
  endfunction

  // An all-zero LFSR would lock up, so zero seeds become 1.
  function automatic logic [ID_W-1:0] f_seed_fix(input logic [ID_W-1:0] v);
    return (v == '0) ? ID_W'(1) : v;
  endfunction

  // Per-channel state
  logic [PERIOD_W-1:0] r_cnt  [NUM_CH];
  logic [ID_W-1:0]     r_ul   [NUM_CH];
  logic [ID_W-1:0]     r_dl   [NUM_CH];
  logic [ID_W-1:0]     r_pid  [NUM_CH];
  logic [7:0]          r_seq  [NUM_CH];
  logic [7:0]          r_pseq [NUM_CH];
  logic [NUM_CH-1:0]   r_alt;
  logic [NUM_CH-1:0]   r_pend;
  logic [NUM_CH-1:0]   r_pdir;
  logic [CH_W-1:0]     r_last;

  logic [NUM_CH-1:0]   w_active;
  logic [NUM_CH-1:0]   w_event;
  logic [NUM_CH-1:0]   w_accept;
  logic [NUM_CH-1:0]   w_drop;
  logic [NUM_CH-1:0]   w_dir;
  logic [NUM_CH-1:0]   w_grant_hit;
  logic [ID_W-1:0]     w_id      [NUM_CH];
  logic [ID_W-1:0]     w_ul_seed [NUM_CH];
  logic [ID_W-1:0]     w_dl_seed [NUM_CH];
  logic                w_grant_vld;
  logic                w_take;
  logic [CH_W-1:0]     w_grant_ch;
  logic [CH_W-1:0]     w_idx;

  // Round-robin arbiter: nearest pending channel after last_grant wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_idx       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CH_W'((32'(r_last) + 32'(k)) % NUM_CH);
      if (r_pend[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_idx;
      end
    end
    w_take = w_grant_vld && (!o_valid || i_ready);
    for (int c = 0; c < NUM_CH; c++) begin
      w_grant_hit[c] = w_take && (w_grant_ch == CH_W'(c));
    end
  end

  // Per-channel event, drop, ID/direction selection and seed values.
  always_comb begin
    w_active = '0;
    w_event  = '0;
    w_accept = '0;
    w_drop   = '0;
    w_dir    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_id[c]      = r_ul[c];
      w_active[c]  = i_ena && (i_ch_mode[2*c +: 2] != ModeIdle);
      w_event[c]   = w_active[c] && (r_cnt[c] >= i_cfg_period[PERIOD_W*c +: PERIOD_W]);
      // A packet being granted this cycle frees the slot for the new event.
      w_drop[c]    = w_event[c] && r_pend[c] && !w_grant_hit[c];
      w_accept[c]  = w_event[c] && !(r_pend[c] && !w_grant_hit[c]);
      case (i_ch_mode[2*c +: 2])
        ModeUl:  begin w_id[c] = r_ul[c]; w_dir[c] = 1'b0; end
        ModeDl:  begin w_id[c] = r_dl[c]; w_dir[c] = 1'b1; end
        ModeAlt: begin w_id[c] = r_alt[c] ? r_dl[c] : r_ul[c]; w_dir[c] = r_alt[c]; end
        default: begin w_id[c] = r_ul[c]; w_dir[c] = 1'b0; end
      endcase
      w_ul_seed[c] = f_seed_fix(f_rotl(i_seed, c));
      w_dl_seed[c] = f_seed_fix(~f_rotl(i_seed, c));
    end
  end

  // Channel state: period counters, LFSRs, sequence and pending slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alt  <= '0;
      r_pend <= '0;
      r_pdir <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= '0;
        r_ul[c]   <= ID_W'(1);
        r_dl[c]   <= ~ID_W'(1);
        r_pid[c]  <= '0;
        r_seq[c]  <= '0;
        r_pseq[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_event[c] || !w_active[c]) r_cnt[c] <= '0;
        else                            r_cnt[c] <= r_cnt[c] + PERIOD_W'(1);
        if (w_grant_hit[c]) r_pend[c] <= 1'b0;
        if (w_accept[c]) begin
          r_pend[c] <= 1'b1;
          r_pid[c]  <= w_id[c];
          r_pdir[c] <= w_dir[c];
          r_pseq[c] <= r_seq[c];
          r_seq[c]  <= r_seq[c] + 8'd1;
          r_ul[c]   <= f_lfsr_next(r_ul[c]);
          r_dl[c]   <= f_lfsr_next(r_dl[c]);
          if (i_ch_mode[2*c +: 2] == ModeAlt) r_alt[c] <= ~r_alt[c];
        end
        // Seed load overrides the event's LFSR advance and alt toggle.
        if (i_seed_load) begin
          r_ul[c]  <= w_ul_seed[c];
          r_dl[c]  <= w_dl_seed[c];
          r_alt[c] <= 1'b0;
        end
      end
    end
  end

  // Output register: loads on grant when empty or being accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_packet_id <= '0;
      o_dir_dl    <= 1'b0;
      o_ch        <= '0;
      o_seq       <= '0;
      r_last      <= CH_W'(NUM_CH - 1);
    end else if (w_take) begin
      o_valid     <= 1'b1;
      o_packet_id <= r_pid[w_grant_ch];
      o_dir_dl    <= r_pdir[w_grant_ch];
      o_ch        <= w_grant_ch;
      o_seq       <= r_pseq[w_grant_ch];
      r_last      <= w_grant_ch;
    end else if (i_ready) begin
      o_valid     <= 1'b0;
    end
  end

  // Drop pulse: any channel dropped an event this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_drop_pulse <= 1'b0;
    else       o_drop_pulse <= |w_drop;
  end

`ifdef TRAFFIC_DROP_CNT_EN
  logic [3:0]  w_drop_sum;
  logic [16:0] w_drop_add;
  logic [15:0] r_drop_cnt;

  // Sum of simultaneous drops added onto the running count.
  always_comb begin
    w_drop_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_drop_sum = w_drop_sum + 4'(w_drop[c]);
    end
    w_drop_add = {1'b0, r_drop_cnt} + 17'(w_drop_sum);
  end

  // Saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)              r_drop_cnt <= '0;
    else if (w_drop_add[16]) r_drop_cnt <= 16'hFFFF;
    else                    r_drop_cnt <= w_drop_add[15:0];
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_traffic_mch_gen.sv
// Bench for traffic_mch_gen (NUM_CH=4, ID_W=8, PERIOD_W=4): directed scenarios
// plus randomized traffic, scored against a per-cycle reference model.
module tb_traffic_mch_gen;
  localparam int NCH = 4;

  typedef struct packed {
    logic [7:0] id;
    logic       dir;
    logic [1:0] ch;
    logic [7:0] seq;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [7:0]  ch_mode;
  logic [15:0] period;
  logic        seed_load;
  logic [7:0]  seed;
  logic        ready;
  logic        o_valid;
  logic [7:0]  o_packet_id;
  logic        o_dir_dl;
  logic [1:0]  o_ch;
  logic [7:0]  o_seq;
  logic        o_drop_pulse;
  logic [15:0] o_drop_cnt;

  always #5 clk = ~clk;

  traffic_mch_gen dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ena        (ena),
    .i_ch_mode    (ch_mode),
    .i_cfg_period (period),
    .i_seed_load  (seed_load),
    .i_seed       (seed),
    .i_ready      (ready),
    .o_valid      (o_valid),
    .o_packet_id  (o_packet_id),
    .o_dir_dl     (o_dir_dl),
    .o_ch         (o_ch),
    .o_seq        (o_seq),
    .o_drop_pulse (o_drop_pulse),
    .o_drop_cnt   (o_drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model
  int         m_cnt  [NCH];
  logic [7:0] m_ul   [NCH];
  logic [7:0] m_dl   [NCH];
  int         m_seq  [NCH];
  bit         m_alt  [NCH];
  bit         m_pend [NCH];
  pkt_t       m_pkt  [NCH];
  bit         m_valid;
  int         m_last;
  int         m_drops;
  bit         m_drop_pulse;
  pkt_t       exp_q[$];
  pkt_t       acc_q[$];
  int         acc_t[$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] rot_raw(input logic [7:0] s, input int c);
    logic [7:0] r;
    r = s;
    for (int i = 0; i < c; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] nz(input logic [7:0] v);
    return (v == 8'h00) ? 8'h01 : v;
  endfunction

  always @(posedge clk) begin : p_model
    int   ndrop;
    int   g;
    bit   got;
    bit   use_dl;
    logic [1:0] md;
    cyc++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_ul[c] = 8'h01; m_dl[c] = 8'hFE;
        m_seq[c] = 0; m_alt[c] = 0; m_pend[c] = 0;
      end
      m_valid = 0; m_last = NCH - 1; m_drops = 0; m_drop_pulse = 0;
      exp_q.delete();
    end else begin
      ndrop = 0;
      if (m_valid && ready) m_valid = 0;
      if (!m_valid) begin
        got = 0;
        for (int k = 1; k <= NCH; k++) begin
          g = (m_last + k) % NCH;
          if (!got && m_pend[g]) begin
            got = 1;
            m_pend[g] = 0;
            m_last = g;
            m_valid = 1;
            exp_q.push_back(m_pkt[g]);
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        md = ch_mode[2*c +: 2];
        if (!ena || md == 2'b00) m_cnt[c] = 0;
        else if (m_cnt[c] >= int'(period[4*c +: 4])) begin
          m_cnt[c] = 0;
          if (m_pend[c]) ndrop++;
          else begin
            use_dl = (md == 2'b10) || (md == 2'b11 && m_alt[c]);
            m_pkt[c].id  = use_dl ? m_dl[c] : m_ul[c];
            m_pkt[c].dir = use_dl;
            m_pkt[c].ch  = 2'(c);
            m_pkt[c].seq = 8'(m_seq[c]);
            m_seq[c] = (m_seq[c] + 1) % 256;
            m_ul[c] = lfsr_step(m_ul[c]);
            m_dl[c] = lfsr_step(m_dl[c]);
            if (md == 2'b11) m_alt[c] = !m_alt[c];
            m_pend[c] = 1;
          end
        end else m_cnt[c]++;
      end
      if (seed_load) begin
        for (int c = 0; c < NCH; c++) begin
          m_ul[c] = nz(rot_raw(seed, c));
          m_dl[c] = nz(~rot_raw(seed, c));
          m_alt[c] = 0;
        end
      end
      m_drop_pulse = (ndrop > 0);
      m_drops = (m_drops + ndrop > 65535) ? 65535 : m_drops + ndrop;
    end
  end

  // Monitor: compares the output stream and drop status against the model.
  bit   hold_v = 0;
  pkt_t hold_p;
  always @(negedge clk) begin : p_mon
    pkt_t cur;
    pkt_t e;
    if (mon_en) begin
      cur = '{id: o_packet_id, dir: o_dir_dl, ch: o_ch, seq: o_seq};
      chk("valid", o_valid, m_valid);
      chk("drop_pulse", o_drop_pulse, m_drop_pulse);
`ifdef TRAFFIC_DROP_CNT_EN
      chk("drop_cnt", o_drop_cnt, m_drops);
`else
      chk("drop_cnt", o_drop_cnt, 0);
`endif
      if (hold_v && o_valid) chk("stall_stable", cur, hold_p);
      hold_v = o_valid && !ready;
      hold_p = cur;
      if (o_valid && ready) begin
        chk("pkt_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pkt", cur, e);
        end
        acc_q.push_back(cur);
        acc_t.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ch_mode = '0; period = '0; seed_load = 0; ready = 1; ena = 1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    step(1);
    rst = 0;
  endtask

  task automatic clr_acc();
    acc_q.delete();
    acc_t.delete();
  endtask

  logic [7:0] exp_ul [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    rst = 1; ena = 0; ch_mode = '0; period = '0; seed_load = 0; seed = '0; ready = 1;
    step(3);
    mon_en = 1;
    chk("rst_valid", o_valid, 0);
    chk("rst_id", o_packet_id, 0);
    chk("rst_seq", o_seq, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_dropcnt", o_drop_cnt, 0);
    rst = 0;

    // UL stream on ch0, P=3
    do_reset(); clr_acc();
    ch_mode = 8'b0000_0001; period = 16'h0003;
    step(22);
    chk("ul_count", acc_q.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_q.size()) begin
        chk("ul_id", acc_q[i].id, exp_ul[i]);
        chk("ul_seq", acc_q[i].seq, i);
        chk("ul_dir", acc_q[i].dir, 0);
        chk("ul_ch", acc_q[i].ch, 0);
        if (i > 0) chk("ul_spacing", acc_t[i] - acc_t[i-1], 4);
      end
    end

    // ALT on ch1, P=0
    do_reset(); clr_acc();
    ch_mode = 8'b0000_1100;
    step(10);
    chk("alt_count", acc_q.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_q.size()) begin
        chk("alt_dir", acc_q[i].dir, i % 2);
        chk("alt_ch", acc_q[i].ch, 1);
      end
    end
    if (acc_q.size() >= 3) begin
      chk("alt_ul_id0", acc_q[0].id, 8'h01);
      chk("alt_ul_id2", acc_q[2].id, 8'h04);
    end

    // Round robin: all channels UL, P=2
    do_reset(); clr_acc();
    ch_mode = 8'h55; period = 16'h2222;
    step(40);
    chk("rr_count", acc_q.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_q.size()) chk("rr_order", acc_q[i].ch, i % 4);
    end

    // Backpressure on ch0, P=0
    do_reset();
    ready = 0; ch_mode = 8'b0000_0001;
    step(10);
    chk("bp_valid", o_valid, 1);
    chk("bp_hold_id", o_packet_id, 8'h01);
    chk("bp_hold_seq", o_seq, 0);
    clr_acc();
    ready = 1;
    step(4);
    if (acc_q.size() >= 2) begin
      chk("bp_first", acc_q[0].id, 8'h01);
      chk("bp_next", acc_q[1].id, 8'h02);
    end else chk("bp_count", acc_q.size(), 2);

    // Seed loads on ch2
    do_reset(); clr_acc();
    seed = 8'h00; seed_load = 1; ch_mode = 8'b0001_0000; period = 16'h0100;
    step(1);
    seed_load = 0;
    step(8);
    if (acc_q.size() >= 1) begin
      chk("seed0_id", acc_q[0].id, 8'h01);
      chk("seed0_ch", acc_q[0].ch, 2);
    end else chk("seed0_count", acc_q.size(), 1);
    ch_mode = '0; step(6);
    seed = 8'h81; seed_load = 1; step(1); seed_load = 0;
    clr_acc(); ch_mode = 8'b0001_0000; step(8);
    if (acc_q.size() >= 1) chk("seed81_ul", acc_q[0].id, 8'h06);
    else chk("seed81_ul_count", acc_q.size(), 1);
    ch_mode = '0; step(6);
    seed_load = 1; step(1); seed_load = 0;
    clr_acc(); ch_mode = 8'b0010_0000; step(8);
    if (acc_q.size() >= 1) begin
      chk("seed81_dl", acc_q[0].id, 8'hF9);
      chk("seed81_dl_dir", acc_q[0].dir, 1);
    end else chk("seed81_dl_count", acc_q.size(), 1);

    // Reset mid-transfer
    do_reset();
    ready = 0; ch_mode = 8'b0000_0001;
    step(4);
    chk("mid_valid_before", o_valid, 1);
    rst = 1; step(1);
    chk("mid_valid_after", o_valid, 0);
    rst = 0; ready = 1; clr_acc();
    step(6);
    if (acc_q.size() >= 1) chk("mid_first_id", acc_q[0].id, 8'h01);
    else chk("mid_count", acc_q.size(), 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      ena = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) begin
        ch_mode = 8'($urandom);
        for (int c = 0; c < NCH; c++) period[4*c +: 4] = 4'($urandom_range(0, 3));
      end
      seed_load = ($urandom_range(0, 49) == 0);
      seed = 8'($urandom_range(1, 254));
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 0; idle_all();
    step(20);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
